// File: rtl/fixed_point_sign_restore.sv
// Restores each operand's original sign onto the shared-ALU result.
// Signs wait in an in-order tag FIFO; results return in issue order.
module fixed_point_sign_restore #(
  parameter int WIDTH     = 8,
  parameter int FRAC_BITS = 3,
  parameter int DEPTH     = 4
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     SIGN_IN,
  input  logic                     SIGN_VALID_IN,
  output logic                     SIGN_READY_OUT,
  input  logic [WIDTH-1:0]         VALUE_IN,
  input  logic                     VALID_IN,
  output logic [WIDTH-1:0]         VALUE_OUT,
  output logic                     VALID_OUT,
  output logic [$clog2(DEPTH):0]   LEVEL_OUT,
  output logic                     TAG_DROP_ERR,
  output logic                     UNDERFLOW_ERR
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 ||
      FRAC_BITS < 0 || FRAC_BITS >= WIDTH) begin : g_bad_param
    $error("fixed_point_sign_restore: bad parameters");
  end

  logic [DEPTH-1:0] mem_q, mem_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic [WIDTH-1:0] value_q, value_d;
  logic             valid_q, valid_d;
  logic             drop_q, drop_d;
  logic             udf_q, udf_d;

  logic             full, empty, push, pop;
  logic             bypass, store, underflow, tag;
  logic [WIDTH-1:0] res;

  always_comb begin
    full      = (level_q == LW'(DEPTH));
    empty     = (level_q == '0);
    push      = SIGN_VALID_IN & ~full;
    pop       = VALID_IN & ~empty;
    bypass    = push & VALID_IN & empty;
    store     = push & ~bypass;
    underflow = VALID_IN & empty & ~push;
    // an empty FIFO hands the incoming sign straight to the result
    tag       = empty ? SIGN_IN : mem_q[rd_ptr_q];

    res = VALUE_IN;
    if (!underflow && VALUE_IN != '0 && VALUE_IN[WIDTH-1] != tag) begin
      res = (VALUE_IN == MIN_NEG) ? MAX_POS : (WIDTH'(0) - VALUE_IN);
    end

    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (store) begin
      mem_d[wr_ptr_q] = SIGN_IN;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    if (store && !pop) begin
      level_d = level_q + LW'(1);
    end else if (pop && !store) begin
      level_d = level_q - LW'(1);
    end

    value_d = VALID_IN ? res : value_q;
    valid_d = VALID_IN;
    drop_d  = drop_q | (SIGN_VALID_IN & full);
    udf_d   = udf_q | underflow;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      value_q  <= '0;
      valid_q  <= 1'b0;
      drop_q   <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      value_q  <= value_d;
      valid_q  <= valid_d;
      drop_q   <= drop_d;
      udf_q    <= udf_d;
    end
  end

  assign SIGN_READY_OUT = ~full;
  assign VALUE_OUT      = value_q;
  assign VALID_OUT      = valid_q;
  assign LEVEL_OUT      = level_q;
  assign TAG_DROP_ERR   = drop_q;
  assign UNDERFLOW_ERR  = udf_q;

endmodule

// File: tb/tb_fixed_point_sign_restore.sv
// Directed bench for fixed_point_sign_restore (WIDTH=8, FRAC_BITS=3).
// Expected results are queued at issue; a monitor pops on each strobe.
module tb_fixed_point_sign_restore;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       SIGN_IN = 1'b0;
  logic       SIGN_VALID_IN = 1'b0;
  logic       SIGN_READY_OUT;
  logic [7:0] VALUE_IN = '0;
  logic       VALID_IN = 1'b0;
  logic [7:0] VALUE_OUT;
  logic       VALID_OUT;
  logic [2:0] LEVEL_OUT;
  logic       TAG_DROP_ERR;
  logic       UNDERFLOW_ERR;

  int n_chk  = 0;
  int n_pass = 0;
  logic [7:0] exp_q[$];

  fixed_point_sign_restore #(
    .WIDTH(8), .FRAC_BITS(3), .DEPTH(4)
  ) dut (
    .CLK           (CLK),
    .RST           (RST),
    .SIGN_IN       (SIGN_IN),
    .SIGN_VALID_IN (SIGN_VALID_IN),
    .SIGN_READY_OUT(SIGN_READY_OUT),
    .VALUE_IN      (VALUE_IN),
    .VALID_IN      (VALID_IN),
    .VALUE_OUT     (VALUE_OUT),
    .VALID_OUT     (VALID_OUT),
    .LEVEL_OUT     (LEVEL_OUT),
    .TAG_DROP_ERR  (TAG_DROP_ERR),
    .UNDERFLOW_ERR (UNDERFLOW_ERR)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input int act, input int req);
    n_chk++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
  endtask

  // drive at negedge, return just after the following posedge
  task automatic tick(input logic sv, input logic s,
                      input logic vv, input logic [7:0] v,
                      input logic [7:0] e);
    @(negedge CLK);
    SIGN_VALID_IN = sv;
    SIGN_IN       = s;
    VALID_IN      = vv;
    VALUE_IN      = v;
    if (vv) exp_q.push_back(e);
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    tick(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    SIGN_VALID_IN = 1'b0;
    VALID_IN      = 1'b0;
    RST = 1'b1;
    #2 RST = 1'b0;
  endtask

  initial begin : monitor
    forever begin
      @(posedge CLK);
      #1;
      if (VALID_OUT) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_valid_out", 1, 0);
        end else begin
          chk("value_out", int'(VALUE_OUT), int'(exp_q.pop_front()));
        end
      end
    end
  end

  initial begin : stim
    #3;
    chk("rst_value", int'(VALUE_OUT), 0);
    chk("rst_valid", int'(VALID_OUT), 0);
    chk("rst_level", int'(LEVEL_OUT), 0);
    chk("rst_ready", int'(SIGN_READY_OUT), 1);
    chk("rst_drop", int'(TAG_DROP_ERR), 0);
    chk("rst_udf", int'(UNDERFLOW_ERR), 0);
    #4 RST = 1'b0;

    // basic restore
    tick(1, 1, 0, 8'h00, 8'h00);
    tick(1, 0, 0, 8'h00, 8'h00);
    chk("basic_level2", int'(LEVEL_OUT), 2);
    tick(0, 0, 1, 8'h0C, 8'hF4);
    tick(0, 0, 1, 8'h10, 8'h10);
    chk("basic_strobe2", int'(VALID_OUT), 1);
    chk("basic_level0", int'(LEVEL_OUT), 0);
    idle();
    chk("basic_strobe_end", int'(VALID_OUT), 0);

    // fill, overflow, drain
    tick(1, 1, 0, 8'h00, 8'h00);
    tick(1, 0, 0, 8'h00, 8'h00);
    tick(1, 1, 0, 8'h00, 8'h00);
    tick(1, 1, 0, 8'h00, 8'h00);
    chk("full_level", int'(LEVEL_OUT), 4);
    chk("full_ready", int'(SIGN_READY_OUT), 0);
    chk("full_drop_clear", int'(TAG_DROP_ERR), 0);
    tick(1, 0, 0, 8'h00, 8'h00);
    chk("drop_err", int'(TAG_DROP_ERR), 1);
    chk("drop_level", int'(LEVEL_OUT), 4);
    tick(0, 0, 1, 8'h08, 8'hF8);
    tick(0, 0, 1, 8'h08, 8'h08);
    tick(0, 0, 1, 8'h08, 8'hF8);
    tick(0, 0, 1, 8'h08, 8'hF8);
    chk("drain_level", int'(LEVEL_OUT), 0);
    chk("drain_ready", int'(SIGN_READY_OUT), 1);

    // wrap-around with push+pop at level 2
    do_reset();
    tick(1, 1, 0, 8'h00, 8'h00);
    tick(1, 0, 0, 8'h00, 8'h00);
    for (int i = 0; i < 10; i++) begin
      tick(1, (i % 2 == 0), 1, 8'h08, (i % 2 == 0) ? 8'hF8 : 8'h08);
      chk($sformatf("wrap_level_%0d", i), int'(LEVEL_OUT), 2);
    end
    tick(0, 0, 1, 8'h08, 8'hF8);
    tick(0, 0, 1, 8'h08, 8'h08);
    chk("wrap_drop", int'(TAG_DROP_ERR), 0);
    chk("wrap_udf", int'(UNDERFLOW_ERR), 0);
    chk("wrap_level_end", int'(LEVEL_OUT), 0);

    // empty bypass then underflow
    tick(1, 1, 1, 8'h0C, 8'hF4);
    chk("bypass_level", int'(LEVEL_OUT), 0);
    chk("bypass_udf", int'(UNDERFLOW_ERR), 0);
    tick(0, 0, 1, 8'h0C, 8'h0C);
    chk("udf_err", int'(UNDERFLOW_ERR), 1);
    idle();
    chk("hold_value", int'(VALUE_OUT), 8'h0C);
    chk("hold_valid", int'(VALID_OUT), 0);

    // edge values
    tick(1, 1, 0, 8'h00, 8'h00);
    tick(0, 0, 1, 8'h00, 8'h00);
    tick(1, 0, 0, 8'h00, 8'h00);
    tick(0, 0, 1, 8'h80, 8'h7F);
    tick(1, 1, 0, 8'h00, 8'h00);
    tick(0, 0, 1, 8'h80, 8'h80);
    tick(1, 0, 0, 8'h00, 8'h00);
    tick(0, 0, 1, 8'hF4, 8'h0C);
    idle();
    chk("edge_udf_sticky", int'(UNDERFLOW_ERR), 1);

    // async reset mid-stream
    tick(1, 1, 0, 8'h00, 8'h00);
    tick(1, 1, 0, 8'h00, 8'h00);
    tick(1, 0, 0, 8'h00, 8'h00);
    chk("ar_level3", int'(LEVEL_OUT), 3);
    @(negedge CLK);
    SIGN_VALID_IN = 1'b0;
    VALID_IN      = 1'b1;
    VALUE_IN      = 8'h0C;
    #2 RST = 1'b1;
    #1;
    chk("ar_value", int'(VALUE_OUT), 0);
    chk("ar_valid", int'(VALID_OUT), 0);
    chk("ar_level", int'(LEVEL_OUT), 0);
    chk("ar_ready", int'(SIGN_READY_OUT), 1);
    chk("ar_udf", int'(UNDERFLOW_ERR), 0);
    chk("ar_drop", int'(TAG_DROP_ERR), 0);
    @(posedge CLK);
    #2;
    chk("ar_no_strobe", int'(VALID_OUT), 0);
    VALID_IN = 1'b0;
    RST = 1'b0;
    idle();
    idle();
    chk("ar_level_after", int'(LEVEL_OUT), 0);

    repeat (3) idle();
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin : watchdog
    #100000;
    $display("FAIL timeout: got running, expected finished");
    $fatal(1);
  end

endmodule
